// File: rtl/gamma_spike_encoder_pkg.sv
// tnn_enc_pkg: shared defaults, window-cycle type, run-state enum and the
// value-to-delay mapping used by every spike lane of gamma_spike_encoder.
// Optional macro ENC_INVERT_EN: intensity coding (larger value spikes earlier).
package tnn_enc_pkg;

  localparam int N_CH_DEF    = 8;
  localparam int GAMMA_DEF   = 24;
  localparam int SPIKE_W_DEF = 8;
  localparam int VAL_W_DEF   = 3;

  // Window cycle index; wide enough for windows of up to 32 cycles.
  typedef logic [4:0] cyc_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Maps a latched channel value to its spike delay within the window.
  // vmax is the all-ones value for the configured value width.
  function automatic cyc_t enc_delay(input cyc_t value, input cyc_t vmax);
`ifdef ENC_INVERT_EN
    return vmax - value;
`else
    // Masking to the value width keeps the delay inside 0..vmax.
    return value & vmax;
`endif
  endfunction

endpackage

// File: rtl/gamma_spike_encoder_if.sv
// gamma_spike_encoder_if: run control, value-load handshake and the
// gamma clock / spike outputs. The encoder is the slave; whoever supplies
// the sensory values and consumes the spikes is the master.
interface gamma_spike_encoder_if
  import tnn_enc_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int VAL_W = VAL_W_DEF
);

  logic                    en;
  logic                    in_req;
  logic [N_CH*VAL_W-1:0]   in_val;
  logic [N_CH-1:0]         in_mask;
  logic                    in_ack;
  logic                    gclk;
  logic [N_CH-1:0]         spike;
  cyc_t                    cyc;

  modport master (
    output en, in_req, in_val, in_mask,
    input  in_ack, gclk, spike, cyc
  );

  modport slave (
    input  en, in_req, in_val, in_mask,
    output in_ack, gclk, spike, cyc
  );

endinterface

// File: rtl/gamma_spike_encoder_spike_lane.sv
// spike_lane: one spike channel. Holds the value and fire mask latched at
// window start and produces a registered spike bit. The bit is computed from
// the next cycle index so that it is high exactly while the current index
// lies inside [1+d, d+SPIKE_W].
module spike_lane
  import tnn_enc_pkg::*;
#(
  parameter int VAL_W   = VAL_W_DEF,
  parameter int SPIKE_W = SPIKE_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             win_start_i,
  input  logic             load_i,
  input  logic [VAL_W-1:0] val_i,
  input  logic             mask_i,
  input  cyc_t             cyc_d_i,
  output logic             spike_o
);

  logic [VAL_W-1:0] val_q, val_d;
  logic             mask_q, mask_d;
  logic             spike_q, spike_d;
  cyc_t             delay;
  cyc_t             win_lo;
  cyc_t             win_hi;

  // Latch on window start: a missing load silences the lane for the whole window.
  always_comb begin
    val_d  = val_q;
    mask_d = mask_q;
    if (win_start_i) begin
      mask_d = load_i & mask_i;
      if (load_i) begin
        val_d = val_i;
      end
    end
    delay   = enc_delay(cyc_t'(val_d), cyc_t'((1 << VAL_W) - 1));
    win_lo  = delay + cyc_t'(1);
    win_hi  = delay + cyc_t'(SPIKE_W);
    spike_d = mask_d && (cyc_d_i >= win_lo) && (cyc_d_i <= win_hi);
  end

  // Lane state; reset kills an in-flight spike immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q   <= '0;
      mask_q  <= 1'b0;
      spike_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      mask_q  <= mask_d;
      spike_q <= spike_d;
    end
  end

  assign spike_o = spike_q;

endmodule

// File: rtl/gamma_spike_encoder.sv
// gamma_spike_encoder: transmit side of the synapse input interface.
// Emits a one-cycle gamma pulse every GAMMA cycles while running and turns
// per-channel values into one time-coded spike per channel per window.
// Optional macro ENC_INVERT_EN: intensity coding (see tnn_enc_pkg::enc_delay).
module gamma_spike_encoder
  import tnn_enc_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int GAMMA   = GAMMA_DEF,
  parameter int SPIKE_W = SPIKE_W_DEF,
  parameter int VAL_W   = VAL_W_DEF
) (
  input  logic                  aclk,
  input  logic                  rst_n,
  gamma_spike_encoder_if.slave  bus
);

  // Every spike must end before the settle tail, and the index must fit cyc_t.
  if ((2**VAL_W + SPIKE_W > GAMMA - SPIKE_W) || (GAMMA > 32) || (GAMMA < 2)) begin : g_bad_cfg
    $error("gamma_spike_encoder: 2**VAL_W + SPIKE_W must be <= GAMMA - SPIKE_W and GAMMA in 2..32");
  end

  localparam cyc_t CYC_LAST = cyc_t'(GAMMA - 1);

  run_state_e       state_q, state_d;
  cyc_t             cyc_q, cyc_d;
  logic             gclk;
  logic             ack;
  logic [N_CH-1:0]  spike_w;

  // Run FSM and window counter: a stop request only takes effect at the wrap.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        if (bus.en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (!bus.en) begin
            state_d = ST_IDLE;
          end
        end else begin
          cyc_d = cyc_q + cyc_t'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  assign gclk = (state_q == ST_RUN) && (cyc_q == '0);
  assign ack  = gclk & bus.in_req;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    spike_lane #(
      .VAL_W   (VAL_W),
      .SPIKE_W (SPIKE_W)
    ) u_lane (
      .clk_i       (aclk),
      .rst_ni      (rst_n),
      .win_start_i (gclk),
      .load_i      (ack),
      .val_i       (bus.in_val[c*VAL_W +: VAL_W]),
      .mask_i      (bus.in_mask[c]),
      .cyc_d_i     (cyc_d),
      .spike_o     (spike_w[c])
    );
  end

  assign bus.gclk   = gclk;
  assign bus.in_ack = ack;
  assign bus.cyc    = cyc_q;
  assign bus.spike  = spike_w;

endmodule
